// File: rtl/verificador_senha.sv
// ============================================================================
// Module      : verificador_senha
// Description : Password checker behind the keypad decoder. It compares
//               packets with the stored code and manages failed-attempt
//               lockout and post-unlock password change.
//               Optional macro DESBLOQUEIO_MESTRE_EN adds a master code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module verificador_senha #(
  parameter int          MIN_DIGITOS    = 4,
  parameter int          MAX_DIGITOS    = 12,
  parameter int          MAX_TENTATIVAS = 3,
  parameter int          T_BLOQUEIO     = 20000,
  parameter int          T_JANELA_CFG   = 10000,
  parameter logic [79:0] SENHA_PADRAO   = 80'hFFFF_FFFF_FFFF_FFFF_1234
`ifdef DESBLOQUEIO_MESTRE_EN
  ,
  parameter logic [79:0] SENHA_MESTRE   = 80'hFFFF_FFFF_FFFF_9999_9999
`endif
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [79:0]                         digitos_value,
  input  logic                                digitos_valid,
  input  logic                                modo_config,
  output logic                                senha_ok,
  output logic                                senha_erro,
  output logic                                config_ok,
  output logic                                bloqueado,
  output logic [$clog2(MAX_TENTATIVAS+1)-1:0] tentativas
);

  localparam int c_TW      = $clog2(MAX_TENTATIVAS + 1);
  localparam int c_TMR_MAX = (T_BLOQUEIO > T_JANELA_CFG) ? T_BLOQUEIO : T_JANELA_CFG;
  localparam int c_TMRW    = $clog2(c_TMR_MAX + 1);

  localparam logic [79:0] c_CANCELA = {20{4'hB}};
  localparam logic [79:0] c_TIMEOUT = {20{4'hE}};

  typedef enum logic [2:0] {
    S_OCIOSO     = 3'd0,
    S_COMPARA    = 3'd1,
    S_ACERTO     = 3'd2,
    S_ERRO       = 3'd3,
    S_BLOQUEIO   = 3'd4,
    S_CFG_JANELA = 3'd5,
    S_CFG_GRAVA  = 3'd6
  } estado_t;

  estado_t           r_estado, w_estado_n;
  logic [79:0]       r_buf;
  logic [79:0]       r_senha;
  logic              r_mestre;
  logic [c_TW-1:0]   r_tent;
  logic [c_TMRW-1:0] r_tmr;
  logic              r_senha_ok, r_senha_erro, r_config_ok, r_bloqueado;
  logic              r_cfg_ok_pend, r_cfg_err_pend;

  logic [4:0]        w_len;
  logic              w_viu_f, w_malformado, w_digito_inv;
  logic              w_len_ok, w_match, w_cancela, w_timeout, w_tmr_zero;
  logic              w_mestre_hit;
  logic [c_TW-1:0]   w_tent_inc;

  logic w_cap, w_do_ok, w_do_err, w_cfg_ok, w_cfg_err;
  logic w_clr_tent, w_inc_tent, w_set_bloq, w_clr_bloq;
  logic w_ld_bloq, w_ld_jan, w_dec_tmr, w_grava, w_restaura;

`ifdef DESBLOQUEIO_MESTRE_EN
  assign w_mestre_hit = digitos_valid && (digitos_value == SENHA_MESTRE);
`else
  assign w_mestre_hit = 1'b0;
`endif

  // Digit 19 sits in nibble 0, so the length is counted from the LSB upward.
  always_comb begin
    w_len        = '0;
    w_viu_f      = 1'b0;
    w_malformado = 1'b0;
    w_digito_inv = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (r_buf[k*4 +: 4] == 4'hF) begin
        w_viu_f = 1'b1;
      end else begin
        if (w_viu_f) w_malformado = 1'b1;
        else         w_len = w_len + 5'd1;
        if (r_buf[k*4 +: 4] > 4'h9) w_digito_inv = 1'b1;
      end
    end
  end

  assign w_len_ok   = !w_malformado && !w_digito_inv &&
                      (w_len >= 5'(MIN_DIGITOS)) && (w_len <= 5'(MAX_DIGITOS));
  assign w_match    = w_len_ok && (r_buf == r_senha);
  assign w_cancela  = (r_buf == c_CANCELA);
  assign w_timeout  = (r_buf == c_TIMEOUT);
  assign w_tmr_zero = (r_tmr == '0);
  assign w_tent_inc = (r_tent == c_TW'(MAX_TENTATIVAS)) ? r_tent : r_tent + c_TW'(1);

  always_comb begin
    w_estado_n = r_estado;
    w_cap      = 1'b0;
    w_do_ok    = 1'b0;
    w_do_err   = 1'b0;
    w_cfg_ok   = 1'b0;
    w_cfg_err  = 1'b0;
    w_clr_tent = 1'b0;
    w_inc_tent = 1'b0;
    w_set_bloq = 1'b0;
    w_clr_bloq = 1'b0;
    w_ld_bloq  = 1'b0;
    w_ld_jan   = 1'b0;
    w_dec_tmr  = 1'b0;
    w_grava    = 1'b0;
    w_restaura = 1'b0;
    if (w_mestre_hit) begin
      // Master code pre-empts whatever the FSM is doing, lockout included.
      w_cap      = 1'b1;
      w_estado_n = S_COMPARA;
    end else begin
      case (r_estado)
        S_OCIOSO: begin
          if (digitos_valid) begin
            w_cap      = 1'b1;
            w_estado_n = S_COMPARA;
          end
        end
        S_COMPARA: begin
          if (r_mestre)                    w_estado_n = S_ACERTO;
          else if (w_cancela || w_timeout) w_estado_n = S_OCIOSO;
          else if (w_match)                w_estado_n = S_ACERTO;
          else                             w_estado_n = S_ERRO;
        end
        S_ACERTO: begin
          w_do_ok    = 1'b1;
          w_clr_tent = 1'b1;
          if (r_mestre) begin
            w_clr_bloq = 1'b1;
            w_restaura = 1'b1;
            w_estado_n = S_OCIOSO;
          end else begin
            w_ld_jan   = 1'b1;
            w_estado_n = S_CFG_JANELA;
          end
        end
        S_ERRO: begin
          w_do_err   = 1'b1;
          w_inc_tent = 1'b1;
          if (w_tent_inc == c_TW'(MAX_TENTATIVAS)) begin
            w_set_bloq = 1'b1;
            w_ld_bloq  = 1'b1;
            w_estado_n = S_BLOQUEIO;
          end else begin
            w_estado_n = S_OCIOSO;
          end
        end
        S_BLOQUEIO: begin
          if (w_tmr_zero) begin
            w_clr_bloq = 1'b1;
            w_clr_tent = 1'b1;
            w_estado_n = S_OCIOSO;
          end else begin
            w_dec_tmr = 1'b1;
          end
        end
        S_CFG_JANELA: begin
          if (digitos_valid) begin
            w_cap      = 1'b1;
            w_estado_n = modo_config ? S_CFG_GRAVA : S_COMPARA;
          end else if (w_tmr_zero) begin
            w_estado_n = S_OCIOSO;
          end else begin
            w_dec_tmr = 1'b1;
          end
        end
        S_CFG_GRAVA: begin
          w_estado_n = S_OCIOSO;
          if (!(w_cancela || w_timeout)) begin
            if (w_len_ok) begin
              w_grava  = 1'b1;
              w_cfg_ok = 1'b1;
            end else begin
              w_cfg_err = 1'b1;
            end
          end
        end
        default: w_estado_n = S_OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado       <= S_OCIOSO;
      r_buf          <= '1;
      r_senha        <= SENHA_PADRAO;
      r_mestre       <= 1'b0;
      r_tent         <= '0;
      r_tmr          <= '0;
      r_senha_ok     <= 1'b0;
      r_senha_erro   <= 1'b0;
      r_config_ok    <= 1'b0;
      r_bloqueado    <= 1'b0;
      r_cfg_ok_pend  <= 1'b0;
      r_cfg_err_pend <= 1'b0;
    end else begin
      r_estado <= w_estado_n;
      if (w_cap) begin
        r_buf    <= digitos_value;
        r_mestre <= w_mestre_hit;
      end
      // Config results wait one cycle so every pulse lands at strobe+2.
      r_cfg_ok_pend  <= w_cfg_ok;
      r_cfg_err_pend <= w_cfg_err;
      r_senha_ok     <= w_do_ok;
      r_senha_erro   <= w_do_err | r_cfg_err_pend;
      r_config_ok    <= r_cfg_ok_pend;

      if (w_clr_tent)      r_tent <= '0;
      else if (w_inc_tent) r_tent <= w_tent_inc;

      if (w_set_bloq)      r_bloqueado <= 1'b1;
      else if (w_clr_bloq) r_bloqueado <= 1'b0;

      if (w_ld_bloq)       r_tmr <= c_TMRW'(T_BLOQUEIO - 1);
      else if (w_ld_jan)   r_tmr <= c_TMRW'(T_JANELA_CFG);
      else if (w_dec_tmr)  r_tmr <= r_tmr - c_TMRW'(1);

      if (w_restaura)      r_senha <= SENHA_PADRAO;
      else if (w_grava)    r_senha <= r_buf;
    end
  end

  assign senha_ok   = r_senha_ok;
  assign senha_erro = r_senha_erro;
  assign config_ok  = r_config_ok;
  assign bloqueado  = r_bloqueado;
  assign tentativas = r_tent;

endmodule

`default_nettype wire

// File: tb/tb_verificador_senha.sv
// ============================================================================
// Module      : tb_verificador_senha
// Description : Directed self-checking bench for verificador_senha.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_verificador_senha;

  localparam int T_BLOQ = 300;
  localparam int T_JAN  = 100;

  localparam logic [79:0] P1234   = 80'hFFFF_FFFF_FFFF_FFFF_1234;
  localparam logic [79:0] P1235   = 80'hFFFF_FFFF_FFFF_FFFF_1235;
  localparam logic [79:0] P567890 = 80'hFFFF_FFFF_FFFF_FF56_7890;
  localparam logic [79:0] P123    = 80'hFFFF_FFFF_FFFF_FFFF_F123;
  localparam logic [79:0] P13DIG  = 80'hFFFF_FFF1_2345_6789_0123;
  localparam logic [79:0] P12F4   = 80'hFFFF_FFFF_FFFF_FFFF_12F4;
  localparam logic [79:0] P12     = 80'hFFFF_FFFF_FFFF_FFFF_FF12;
  localparam logic [79:0] PCANC   = {20{4'hB}};
  localparam logic [79:0] PTOUT   = {20{4'hE}};
  localparam logic [79:0] PMESTRE = 80'hFFFF_FFFF_FFFF_9999_9999;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] digitos_value;
  logic        digitos_valid;
  logic        modo_config;
  logic        senha_ok, senha_erro, config_ok, bloqueado;
  logic [1:0]  tentativas;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int e_lock;
  int n_wait;

  wire [5:0] obs = {senha_ok, senha_erro, config_ok, bloqueado, tentativas};

  verificador_senha #(
    .T_BLOQUEIO   (T_BLOQ),
    .T_JANELA_CFG (T_JAN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .digitos_value (digitos_value),
    .digitos_valid (digitos_valid),
    .modo_config   (modo_config),
    .senha_ok      (senha_ok),
    .senha_erro    (senha_erro),
    .config_ok     (config_ok),
    .bloqueado     (bloqueado),
    .tentativas    (tentativas)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ev(input logic ok, input logic err, input logic cfg,
                                    input logic blq, input logic [1:0] t);
    return {ok, err, cfg, blq, t};
  endfunction

  // One strobe; pulses must be quiet at strobe+1 and match exp at strobe+2.
  task automatic send(input string tag, input logic [79:0] v, input logic cfg,
                      input logic [5:0] exp);
    @(negedge clk);
    digitos_value = v;
    digitos_valid = 1'b1;
    modo_config   = cfg;
    @(posedge clk); #1;
    digitos_valid = 1'b0;
    modo_config   = 1'b0;
    @(posedge clk); #1;
    check({tag, "@n1"}, obs[5:3], 3'b000);
    @(posedge clk); #1;
    check(tag, obs, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    digitos_value = '1;
    digitos_valid = 1'b0;
    modo_config   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset", obs, ev(0, 0, 0, 0, 2'd0));

    send("ok_1234", P1234, 1'b0, ev(1, 0, 0, 0, 2'd0));

    send("err1", P1235, 1'b0, ev(0, 1, 0, 0, 2'd1));
    send("err2", P1235, 1'b0, ev(0, 1, 0, 0, 2'd2));
    send("err3", P1235, 1'b0, ev(0, 1, 0, 1, 2'd3));
    e_lock = cyc;
    send("lock_ignore", P1234, 1'b0, ev(0, 0, 0, 1, 2'd3));
    n_wait = e_lock + T_BLOQ - 1 - cyc;
    repeat (n_wait) @(posedge clk);
    #1;
    check("lock_hold", obs, ev(0, 0, 0, 1, 2'd3));
    @(posedge clk); #1;
    check("lock_release", obs, ev(0, 0, 0, 0, 2'd0));

    send("err_pre_cancel", P1235, 1'b0, ev(0, 1, 0, 0, 2'd1));
    send("cancel", PCANC, 1'b0, ev(0, 0, 0, 0, 2'd1));
    send("timeout", PTOUT, 1'b0, ev(0, 0, 0, 0, 2'd1));

    send("unlock", P1234, 1'b0, ev(1, 0, 0, 0, 2'd0));
    send("cfg_new", P567890, 1'b1, ev(0, 0, 1, 0, 2'd0));
    send("old_code", P1234, 1'b0, ev(0, 1, 0, 0, 2'd1));
    send("new_code", P567890, 1'b0, ev(1, 0, 0, 0, 2'd0));
    send("cfg_short", P12, 1'b1, ev(0, 1, 0, 0, 2'd0));

    send("len3", P123, 1'b0, ev(0, 1, 0, 0, 2'd1));
    send("len13", P13DIG, 1'b0, ev(0, 1, 0, 0, 2'd2));
    send("malformed", P12F4, 1'b0, ev(0, 1, 0, 1, 2'd3));

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_lock", obs, ev(0, 0, 0, 0, 2'd0));
    send("default_back", P1234, 1'b0, ev(1, 0, 0, 0, 2'd0));

    // Second strobe lands in COMPARA and must be dropped.
    @(negedge clk);
    digitos_value = P1234;
    digitos_valid = 1'b1;
    @(posedge clk); #1;
    digitos_value = P1235;
    @(posedge clk); #1;
    digitos_valid = 1'b0;
    check("b2b@n1", obs[5:3], 3'b000);
    @(posedge clk); #1;
    check("b2b_first", obs, ev(1, 0, 0, 0, 2'd0));
    @(posedge clk); #1;
    check("b2b_dropped", obs, ev(0, 0, 0, 0, 2'd0));

`ifdef DESBLOQUEIO_MESTRE_EN
    send("m_cfg", P567890, 1'b1, ev(0, 0, 1, 0, 2'd0));
    send("m_err1", P1235, 1'b0, ev(0, 1, 0, 0, 2'd1));
    send("m_err2", P1235, 1'b0, ev(0, 1, 0, 0, 2'd2));
    send("m_err3", P1235, 1'b0, ev(0, 1, 0, 1, 2'd3));
    send("mestre", PMESTRE, 1'b0, ev(1, 0, 0, 0, 2'd0));
    send("m_restored", P1234, 1'b0, ev(1, 0, 0, 0, 2'd0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
